// File: rtl/sd_arbiter.sv
// sd_arbiter: two-requester round-robin arbiter in front of a single SD io
// controller. Each requester latches a sector read/write on a rising request
// level; the FSM hands the sd port to one requester at a time, runs a
// strobe/ack handshake and returns a one-cycle done pulse. The byte buffer port
// is muxed combinationally by the current grant.
//
// Optional build macro: SD_ARB_TIMEOUT_EN adds a TIMEOUT_W-bit ack watchdog
// that aborts a stuck handshake with a one-cycle err pulse instead of done.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; pick a pending requester and grant it
//   REQ   | sd_rd/sd_wr asserted, waiting for synchronized ack to go high
//   ACK   | strobe dropped, waiting for synchronized ack to return low
//   DONE  | one cycle: done (or err) pulse, clear pend and grant
module sd_arbiter #(
    parameter int TIMEOUT_W = 24
) (
    input  logic        clk_sys,
    input  logic        reset_n,

    input  logic [31:0] req0_lba,
    input  logic        req0_rd,
    input  logic        req0_wr,
    input  logic [9:0]  req0_addr,
    input  logic [7:0]  req0_din,
    input  logic        req0_din_wr,
    output logic        req0_busy,
    output logic        req0_done,
    output logic        req0_err,

    input  logic [31:0] req1_lba,
    input  logic        req1_rd,
    input  logic        req1_wr,
    input  logic [9:0]  req1_addr,
    input  logic [7:0]  req1_din,
    input  logic        req1_din_wr,
    output logic        req1_busy,
    output logic        req1_done,
    output logic        req1_err,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [9:0]  sd_addr,
    output logic [7:0]  sd_din,
    output logic        sd_din_wr,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [1:0]  lvl;
    logic [1:0]  hist_q;
    logic [1:0]  rise;
    logic [1:0]  pend_q;
    logic [1:0]  pend_clr;
    logic [1:0]  op_wr_q;
    logic [31:0] lba_cap0_q, lba_cap1_q;

    logic        ack_meta_q, ack_sync_q;

    logic [1:0]  grant_q, grant_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] lba_q, lba_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        last_q, last_d;   // 1 = requester 1 was served last

    logic [1:0]  win;
    logic        win_wr;
    logic        tmo_hit;

    // A new request is only an edge of the combined level, and only when that
    // requester is neither pending nor being served.
    assign lvl  = {req1_rd | req1_wr, req0_rd | req0_wr};
    assign rise = lvl & ~hist_q & ~pend_q & ~grant_q;

    // pend is released in the DONE cycle for the owner only.
    assign pend_clr = (state_q == DONE) ? grant_q : 2'b00;

    // Edge history resets to 1 so a level held through reset is not a new request.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hist_q     <= 2'b11;
            pend_q     <= 2'b00;
            op_wr_q    <= 2'b00;
            lba_cap0_q <= '0;
            lba_cap1_q <= '0;
        end else begin
            hist_q <= lvl;
            pend_q <= (pend_q & ~pend_clr) | rise;
            if (rise[0]) begin
                op_wr_q[0] <= req0_wr & ~req0_rd;
                lba_cap0_q <= req0_lba;
            end
            if (rise[1]) begin
                op_wr_q[1] <= req1_wr & ~req1_rd;
                lba_cap1_q <= req1_lba;
            end
        end
    end

    // Two-flop synchronizer for the io controller's acknowledge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= sd_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    // Round-robin pick: a lone requester always wins, a tie goes to the one
    // not served last.
    always_comb begin
        win = 2'b00;
        case (pend_q)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_q ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    assign win_wr = win[1] ? op_wr_q[1] : op_wr_q[0];

`ifdef SD_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] tmo_cnt_q;

    // Watchdog counts every cycle spent in the handshake; it is zero in IDLE,
    // so it always starts from zero on entry to REQ.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == REQ || state_q == ACK) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Fires in the cycle whose clock edge brings the counter to all-ones, so
    // the abort lands exactly when the counter saturates.
    assign tmo_hit = (state_q == REQ || state_q == ACK) && (tmo_cnt_q == TMO_LAST);
`else
    logic [TIMEOUT_W-1:0] unused_tmo_w;
    assign unused_tmo_w = '0;
    assign tmo_hit      = 1'b0;
`endif

    // Next-state and registered-output logic of the handshake FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        lba_d   = lba_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    grant_d = win;
                    lba_d   = win[1] ? lba_cap1_q : lba_cap0_q;
                    rd_d    = ~win_wr;
                    wr_d    = win_wr;
                    last_d  = win[1];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (tmo_hit) begin
                    err_d   = grant_q;
                    state_d = DONE;
                end else if (ack_sync_q) begin
                    state_d = ACK;
                end else begin
                    rd_d = rd_q;
                    wr_d = wr_q;
                end
            end
            ACK: begin
                if (tmo_hit) begin
                    err_d   = grant_q;
                    state_d = DONE;
                end else if (!ack_sync_q) begin
                    done_d  = grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            lba_q   <= '0;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            lba_q   <= lba_d;
            done_q  <= done_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Byte buffer port follows the owner; requester 0 drives address/data
    // when idle, but no write strobe gets through without a grant.
    always_comb begin
        sd_addr   = grant_q[1] ? req1_addr : req0_addr;
        sd_din    = grant_q[1] ? req1_din  : req0_din;
        sd_din_wr = (req0_din_wr & grant_q[0]) | (req1_din_wr & grant_q[1]);
    end

    assign grant     = grant_q;
    assign sd_rd     = rd_q;
    assign sd_wr     = wr_q;
    assign sd_lba    = lba_q;
    assign req0_busy = pend_q[0] | grant_q[0];
    assign req1_busy = pend_q[1] | grant_q[1];
    assign req0_done = done_q[0];
    assign req1_done = done_q[1];
    assign req0_err  = err_q[0];
    assign req1_err  = err_q[1];

endmodule

// File: tb/tb_sd_arbiter.sv
// Bench for sd_arbiter. Stimulus pushes the expected strobe (owner, op, LBA)
// and completion pulse of every transaction into queues; a negedge monitor
// pops and compares whenever the DUT raises a strobe or a done/err pulse.
module tb_sd_arbiter;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 24;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] req0_lba = '0, req1_lba = '0;
    logic        req0_rd = 1'b0, req0_wr = 1'b0, req1_rd = 1'b0, req1_wr = 1'b0;
    logic [9:0]  req0_addr = '0, req1_addr = '0;
    logic [7:0]  req0_din = '0, req1_din = '0;
    logic        req0_din_wr = 1'b0, req1_din_wr = 1'b0;
    logic        req0_busy, req0_done, req0_err, req1_busy, req1_done, req1_err;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [9:0]  sd_addr;
    logic [7:0]  sd_din;
    logic        sd_din_wr;
    logic [1:0]  grant;

    sd_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .req0_lba(req0_lba), .req0_rd(req0_rd), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_din(req0_din), .req0_din_wr(req0_din_wr),
        .req0_busy(req0_busy), .req0_done(req0_done), .req0_err(req0_err),
        .req1_lba(req1_lba), .req1_rd(req1_rd), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_din(req1_din), .req1_din_wr(req1_din_wr),
        .req1_busy(req1_busy), .req1_done(req1_done), .req1_err(req1_err),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_din_wr(sd_din_wr),
        .grant(grant)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  op;     // {sd_wr, sd_rd}
        logic [31:0] lba;
    } start_t;

    start_t     exp_start[$];
    logic [3:0] exp_end[$];  // {req1_err, req0_err, req1_done, req0_done}

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_txn(input logic [1:0] gnt, input logic [1:0] op,
                            input logic [31:0] lba, input logic [3:0] fin);
        start_t s;
        s.gnt = gnt; s.op = op; s.lba = lba;
        exp_start.push_back(s);
        exp_end.push_back(fin);
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!(sd_rd | sd_wr) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk({name, "_strobe_timeout"}, 32'(sd_rd | sd_wr), 32'd1);
    endtask

    task automatic ack_cycle(input string name, input int len);
        int n = 0;
        sd_ack = 1'b1;
        repeat (len) tick();
        sd_ack = 1'b0;
        while (!(req0_done | req1_done | req0_err | req1_err) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk({name, "_done_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: compares every strobe start and completion pulse.
    logic prev_strobe = 1'b0;
    always @(negedge clk_sys) begin
        start_t     s;
        logic [3:0] ends;
        logic [3:0] e;
        if (!reset_n) begin
            prev_strobe = 1'b0;
        end else begin
            if ((sd_rd | sd_wr) && !prev_strobe) begin
                if (exp_start.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, sd_wr, sd_rd}, 32'd0);
                end else begin
                    s = exp_start.pop_front();
                    chk("start_grant", {30'd0, grant}, {30'd0, s.gnt});
                    chk("start_op", {30'd0, sd_wr, sd_rd}, {30'd0, s.op});
                    chk("start_lba", sd_lba, s.lba);
                end
            end
            prev_strobe = sd_rd | sd_wr;
            ends = {req1_err, req0_err, req1_done, req0_done};
            if (ends != 4'b0000) begin
                if (exp_end.size() == 0) begin
                    chk("unexpected_end", {28'd0, ends}, 32'd0);
                end else begin
                    e = exp_end.pop_front();
                    chk("end_pulse", {28'd0, ends}, {28'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state.
        #1;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_strobe", {30'd0, sd_wr, sd_rd}, 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_busy_done_err", {26'd0, req1_busy, req0_busy, req1_done, req0_done, req1_err, req0_err}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Idle mux: requester 0 address/data shown, no write strobe.
        req0_addr = 10'h123; req0_din = 8'h5A; req0_din_wr = 1'b1;
        #1;
        chk("idle_addr", {22'd0, sd_addr}, 32'h123);
        chk("idle_din", {24'd0, sd_din}, 32'h5A);
        chk("idle_din_wr", {31'd0, sd_din_wr}, 32'd0);
        req0_din_wr = 1'b0;

        // Single read with exact timing.
        req0_lba = 32'h0000_1234;
        req0_rd  = 1'b1;
        push_txn(2'b01, 2'b01, 32'h0000_1234, 4'b0001);
        tick();
        chk("rd_c1_strobe", {31'd0, sd_rd}, 32'd0);
        chk("rd_c1_busy", {31'd0, req0_busy}, 32'd1);
        tick();
        chk("rd_c2_strobe", {31'd0, sd_rd}, 32'd1);
        chk("rd_c2_grant", {30'd0, grant}, 32'h1);
        sd_ack = 1'b1;
        repeat (3) tick();
        chk("rd_ack_strobe_low", {31'd0, sd_rd}, 32'd0);
        chk("rd_ack_lba_hold", sd_lba, 32'h0000_1234);
        repeat (7) tick();
        sd_ack = 1'b0;
        n = 0;
        while (!req0_done && n < 20) begin
            tick();
            n++;
        end
        chk("rd_done_latency", n, 32'd3);
        tick();
        chk("rd_done_width", {31'd0, req0_done}, 32'd0);
        chk("rd_grant_idle", {30'd0, grant}, 32'd0);
        chk("rd_busy_idle", {31'd0, req0_busy}, 32'd0);
        req0_rd = 1'b0;
        tick();

        // Contention from a fresh reset: requester 0 first, then 1.
        pulse_reset();
        req0_lba = 32'hAAAA_0001; req0_wr = 1'b1;
        req1_lba = 32'hBBBB_0002; req1_rd = 1'b1;
        push_txn(2'b01, 2'b10, 32'hAAAA_0001, 4'b0001);
        push_txn(2'b10, 2'b01, 32'hBBBB_0002, 4'b0010);
        wait_strobe("cont1a");
        ack_cycle("cont1a", 3);
        wait_strobe("cont1b");
        ack_cycle("cont1b", 3);
        req0_wr = 1'b0; req1_rd = 1'b0;
        tick();

        // rd and wr together count as a read; requester 0 becomes last served.
        req0_lba = 32'h0C0C_0003; req0_rd = 1'b1; req0_wr = 1'b1;
        push_txn(2'b01, 2'b01, 32'h0C0C_0003, 4'b0001);
        wait_strobe("rdwr");
        ack_cycle("rdwr", 4);
        req0_rd = 1'b0; req0_wr = 1'b0;
        tick();

        // Repeated dual request: requester 1 wins; exercise the byte mux.
        req0_lba = 32'hDDDD_0004; req0_rd = 1'b1;
        req1_lba = 32'hEEEE_0005; req1_wr = 1'b1;
        push_txn(2'b10, 2'b10, 32'hEEEE_0005, 4'b0010);
        push_txn(2'b01, 2'b01, 32'hDDDD_0004, 4'b0001);
        wait_strobe("cont2a");
        req0_addr = 10'h055; req0_din = 8'h3C; req0_din_wr = 1'b1;
        req1_addr = 10'h1FF; req1_din = 8'hA5; req1_din_wr = 1'b0;
        #1;
        chk("mux_addr", {22'd0, sd_addr}, 32'h1FF);
        chk("mux_din", {24'd0, sd_din}, 32'hA5);
        chk("mux_ignore_req0_wr", {31'd0, sd_din_wr}, 32'd0);
        req1_din_wr = 1'b1;
        #1;
        chk("mux_req1_wr", {31'd0, sd_din_wr}, 32'd1);
        req0_din_wr = 1'b0; req1_din_wr = 1'b0;
        ack_cycle("cont2a", 3);
        wait_strobe("cont2b");
        ack_cycle("cont2b", 3);
        req0_rd = 1'b0; req1_wr = 1'b0;
        tick();

        // Reset while in ACK: everything clears at once, no done, no retrigger.
        req0_lba = 32'hF00D_0006; req0_rd = 1'b1;
        exp_start.push_back('{gnt: 2'b01, op: 2'b01, lba: 32'hF00D_0006});
        wait_strobe("abort");
        sd_ack = 1'b1;
        n = 0;
        while (sd_rd && n < 10) begin
            tick();
            n++;
        end
        chk("abort_in_ack", {31'd0, sd_rd}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_grant", {30'd0, grant}, 32'd0);
        chk("abort_busy", {31'd0, req0_busy}, 32'd0);
        chk("abort_lba", sd_lba, 32'd0);
        tick();
        sd_ack = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("abort_no_retrigger_busy", {31'd0, req0_busy}, 32'd0);
        chk("abort_no_retrigger_grant", {30'd0, grant}, 32'd0);
        req0_rd = 1'b0;
        tick();
        req0_lba = 32'h0000_0007; req0_rd = 1'b1;
        push_txn(2'b01, 2'b01, 32'h0000_0007, 4'b0001);
        wait_strobe("post_abort");
        ack_cycle("post_abort", 3);
        req0_rd = 1'b0;
        tick();

`ifdef SD_ARB_TIMEOUT_EN
        // Watchdog: no ack, err pulse 15 cycles after REQ entry.
        req0_lba = 32'h7777_0008; req0_rd = 1'b1;
        push_txn(2'b01, 2'b01, 32'h7777_0008, 4'b0100);
        wait_strobe("tmo");
        n = 0;
        while (!req0_err && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, 32'd15);
        chk("tmo_strobe_low", {31'd0, sd_rd}, 32'd0);
        chk("tmo_no_done", {31'd0, req0_done}, 32'd0);
        tick();
        chk("tmo_grant_idle", {30'd0, grant}, 32'd0);
        req0_rd = 1'b0;
        tick();
        req0_lba = 32'h7777_0009; req0_rd = 1'b1;
        push_txn(2'b01, 2'b01, 32'h7777_0009, 4'b0001);
        wait_strobe("tmo_next");
        ack_cycle("tmo_next", 3);
        req0_rd = 1'b0;
        tick();
`else
        // No watchdog: a missing ack leaves the strobe up indefinitely.
        req0_lba = 32'h8888_000A; req0_rd = 1'b1;
        exp_start.push_back('{gnt: 2'b01, op: 2'b01, lba: 32'h8888_000A});
        wait_strobe("noack");
        repeat (2000) tick();
        chk("noack_strobe_held", {31'd0, sd_rd}, 32'd1);
        chk("noack_no_err", {31'd0, req0_err}, 32'd0);
        chk("noack_grant", {30'd0, grant}, 32'h1);
        req0_rd = 1'b0;
        pulse_reset();
`endif

        repeat (3) tick();
        chk("exp_start_drained", exp_start.size(), 32'd0);
        chk("exp_end_drained", exp_end.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
